// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: PC, single-outstanding ibus fetch, IF/ID register
// One fetch in flight at a time; a one-entry buffer absorbs a response that lands during a stall.
module ifu #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        if_stall,
  input  logic        if_flush,
  input  logic [31:0] branch_target,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ready,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  output logic        if2id_valid,
  output logic [31:0] if2id_pc,
  output logic [31:0] if2id_instr
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        discard;
  logic        hold_valid;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;

  logic        rsp;
  logic        rsp_live;
  logic        hold_valid_nxt;
  logic        accept;

  // Responses only count in WAIT; anything seen in BOOT or REQ has no matching request.
  always_comb begin
    rsp            = (state == WAIT) && ibus_rvalid;
    rsp_live       = rsp && !discard && !if_flush;
    hold_valid_nxt = !if_flush && if_stall && (hold_valid || rsp_live);
    ibus_req       = ((state == REQ) || (rsp && !discard)) && !if_flush && !hold_valid_nxt;
    ibus_addr      = pc;
    accept         = ibus_req && ibus_ready;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      req_pc      <= RESET_VECTOR;
      discard     <= 1'b0;
      hold_valid  <= 1'b0;
      hold_pc     <= RESET_VECTOR;
      hold_instr  <= NOP_INSTR;
      if2id_valid <= 1'b0;
      if2id_pc    <= RESET_VECTOR;
      if2id_instr <= NOP_INSTR;
    end else begin
      if (accept) begin
        req_pc <= pc;
        pc     <= pc + 32'd4;
      end

      if (if_flush) begin
        pc <= {branch_target[31:2], 2'b00};
        // A fetch still in flight must have its late response swallowed.
        if ((state == WAIT) && !ibus_rvalid) begin
          discard <= 1'b1;
          state   <= WAIT;
        end else begin
          discard <= 1'b0;
          state   <= REQ;
        end
      end else begin
        case (state)
          BOOT: state <= REQ;
          REQ: begin
            if (accept) state <= WAIT;
          end
          WAIT: begin
            if (ibus_rvalid) begin
              discard <= 1'b0;
              state   <= accept ? WAIT : REQ;
            end
          end
          default: state <= BOOT;
        endcase
      end

      hold_valid <= hold_valid_nxt;
      if (if_stall && rsp_live) begin
        hold_pc    <= req_pc;
        hold_instr <= ibus_rdata;
      end

      if (if_flush) begin
        if2id_valid <= 1'b0;
        if2id_instr <= NOP_INSTR;
      end else if (!if_stall) begin
        if (hold_valid) begin
          if2id_valid <= 1'b1;
          if2id_pc    <= hold_pc;
          if2id_instr <= hold_instr;
        end else if (rsp_live) begin
          if2id_valid <= 1'b1;
          if2id_pc    <= req_pc;
          if2id_instr <= ibus_rdata;
        end else begin
          if2id_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - directed and randomized self-checking bench for ifu
// Memory model answers in order with programmable latency; rdata = addr ^ data_key.
module tb_ifu;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_RV = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b, if_stall, if_flush, ibus_ready, ibus_rvalid;
  logic [31:0] branch_target, ibus_rdata;
  logic        ibus_req, if2id_valid;
  logic [31:0] ibus_addr, if2id_pc, if2id_instr;

  logic        w_rst_b, w_stall, w_flush, w_ready, w_rvalid;
  logic [31:0] w_tgt, w_rdata;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_instr;

  int checks   = 0;
  int failures = 0;

  logic        pend;
  logic [31:0] pend_addr;
  int          pend_wait;
  int          lat;
  logic [31:0] data_key;
  logic        spur;
  logic        req_seen, acc_seen;
  logic [31:0] addr_seen;

  ifu dut (
    .clk(clk), .rst_b(rst_b), .if_stall(if_stall), .if_flush(if_flush),
    .branch_target(branch_target), .ibus_req(ibus_req), .ibus_addr(ibus_addr),
    .ibus_ready(ibus_ready), .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
    .if2id_valid(if2id_valid), .if2id_pc(if2id_pc), .if2id_instr(if2id_instr)
  );

  ifu #(.RESET_VECTOR(WRAP_RV)) u_wrap (
    .clk(clk), .rst_b(w_rst_b), .if_stall(w_stall), .if_flush(w_flush),
    .branch_target(w_tgt), .ibus_req(w_req), .ibus_addr(w_addr),
    .ibus_ready(w_ready), .ibus_rvalid(w_rvalid), .ibus_rdata(w_rdata),
    .if2id_valid(w_valid), .if2id_pc(w_pc), .if2id_instr(w_instr)
  );

  // One bus cycle: drive at negedge, sample combinational request, advance memory model at posedge.
  task automatic tick(input logic stall, input logic flush, input logic [31:0] tgt, input logic rdy);
    logic hit;
    hit           = pend && (pend_wait == 0);
    if_stall      = stall;
    if_flush      = flush;
    branch_target = tgt;
    ibus_ready    = rdy;
    ibus_rvalid   = spur || hit;
    ibus_rdata    = hit ? (pend_addr ^ data_key) : 32'hDEAD_BEEF;
    #1;
    req_seen  = ibus_req;
    addr_seen = ibus_addr;
    acc_seen  = ibus_req && rdy;
    @(posedge clk);
    if (hit) pend = 1'b0;
    else if (pend) pend_wait--;
    if (acc_seen) begin
      checks++;
      if (pend) begin
        failures++;
        $display("FAIL outstanding: accept of %h while %h still pending", addr_seen, pend_addr);
      end
      pend      = 1'b1;
      pend_addr = addr_seen;
      pend_wait = lat;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_b = 1'b0; pend = 1'b0; spur = 1'b0; lat = 0; data_key = 32'h0;
    if_stall = 1'b0; if_flush = 1'b0; branch_target = 32'h0;
    ibus_ready = 1'b1; ibus_rvalid = 1'b0; ibus_rdata = 32'h0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ibus_req, ibus_addr} !== {1'b0, 32'h0}) begin
      failures++; $display("FAIL reset_bus: got req=%b addr=%h want 0/0", ibus_req, ibus_addr);
    end
    checks++;
    if ({if2id_valid, if2id_pc, if2id_instr} !== {1'b0, 32'h0, NOP}) begin
      failures++; $display("FAIL reset_ifid: got %b %h %h want 0 0 %h", if2id_valid, if2id_pc, if2id_instr, NOP);
    end
    rst_b = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] e;
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (req_seen !== (k >= 2) || (k >= 2 && addr_seen !== 32'(4 * (k - 2)))) begin
        failures++; $display("FAIL stream_req c%0d: got req=%b addr=%h", k, req_seen, addr_seen);
      end
      e = 32'(4 * (k - 3));
      checks++;
      if (k >= 3 ? ({if2id_valid, if2id_pc, if2id_instr} !== {1'b1, e, e}) : (if2id_valid !== 1'b0)) begin
        failures++; $display("FAIL stream_ifid c%0d: got %b %h %h want pc %h", k, if2id_valid, if2id_pc, if2id_instr, e);
      end
    end
  endtask

  task automatic test_stall();
    do_reset(); rst_b = 1'b1;
    repeat (5) tick(1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 6; k <= 8; k++) begin
      tick(1'b1, 1'b0, 32'h0, 1'b1);
      checks++;
      if (req_seen !== 1'b0 || {if2id_valid, if2id_pc} !== {1'b1, 32'h8}) begin
        failures++; $display("FAIL stall_hold c%0d: got req=%b valid=%b pc=%h want 0 1 8", k, req_seen, if2id_valid, if2id_pc);
      end
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({req_seen, addr_seen} !== {1'b1, 32'h10}) begin
      failures++; $display("FAIL stall_resume_req: got %b %h want 1 00000010", req_seen, addr_seen);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({if2id_valid, if2id_pc, if2id_instr} !== {1'b1, 32'(12 + 4 * k), 32'(12 + 4 * k)}) begin
        failures++; $display("FAIL stall_release %0d: got %b %h want pc %h", k, if2id_valid, if2id_pc, 12 + 4 * k);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1);
    end
  endtask

  task automatic test_flush_outstanding();
    do_reset(); rst_b = 1'b1;
    repeat (9) tick(1'b0, 1'b0, 32'h0, 1'b1);
    lat = 3;
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    lat = 0;
    checks++;
    if (addr_seen !== 32'h20) begin
      failures++; $display("FAIL flush_setup: got addr %h want 00000020", addr_seen);
    end
    tick(1'b0, 1'b1, 32'h100, 1'b1);
    for (int k = 11; k <= 14; k++) begin
      if (k > 11) tick(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (req_seen !== 1'b0 || if2id_valid !== 1'b0) begin
        failures++; $display("FAIL flush_wait c%0d: got req=%b valid=%b want 0 0", k, req_seen, if2id_valid);
      end
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({req_seen, addr_seen, if2id_valid} !== {1'b1, 32'h100, 1'b0}) begin
      failures++; $display("FAIL flush_redirect: got req=%b addr=%h valid=%b want 1 100 0", req_seen, addr_seen, if2id_valid);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({if2id_valid, if2id_pc, if2id_instr} !== {1'b1, 32'h100, 32'h100}) begin
      failures++; $display("FAIL flush_target_ifid: got %b %h %h want 1 100 100", if2id_valid, if2id_pc, if2id_instr);
    end
  endtask

  task automatic test_flush_stall();
    do_reset(); rst_b = 1'b1;
    repeat (5) tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b1, 1'b1, 32'h203, 1'b1);
    checks++;
    if ({req_seen, if2id_valid, if2id_instr} !== {1'b0, 1'b0, NOP}) begin
      failures++; $display("FAIL flush_stall_ifid: got req=%b valid=%b instr=%h", req_seen, if2id_valid, if2id_instr);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({req_seen, addr_seen} !== {1'b1, 32'h200}) begin
      failures++; $display("FAIL flush_stall_req: got %b %h want 1 00000200", req_seen, addr_seen);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({if2id_valid, if2id_pc} !== {1'b1, 32'h200}) begin
      failures++; $display("FAIL flush_stall_deliver: got %b %h want 1 200", if2id_valid, if2id_pc);
    end
  endtask

  task automatic test_backpressure();
    do_reset(); rst_b = 1'b1;
    repeat (5) tick(1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 6; k <= 11; k++) begin
      tick(1'b0, 1'b0, 32'h0, (k >= 10));
      if (k <= 9) begin
        checks++;
        if ({req_seen, addr_seen} !== {1'b1, 32'h10}) begin
          failures++; $display("FAIL bp_req c%0d: got %b %h want 1 00000010", k, req_seen, addr_seen);
        end
      end
      checks++;
      if (k == 6 ? ({if2id_valid, if2id_pc} !== {1'b1, 32'hC}) :
          k == 11 ? ({if2id_valid, if2id_pc} !== {1'b1, 32'h10}) : (if2id_valid !== 1'b0)) begin
        failures++; $display("FAIL bp_ifid c%0d: got valid=%b pc=%h", k, if2id_valid, if2id_pc);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(); rst_b = 1'b1;
    repeat (9) tick(1'b0, 1'b0, 32'h0, 1'b1);
    lat = 3;
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if ({ibus_req, ibus_addr, if2id_valid, if2id_pc, if2id_instr} !== {1'b0, 32'h0, 1'b0, 32'h0, NOP}) begin
      failures++; $display("FAIL async_reset: got req=%b addr=%h valid=%b pc=%h instr=%h",
                           ibus_req, ibus_addr, if2id_valid, if2id_pc, if2id_instr);
    end
    pend = 1'b0; lat = 0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    spur = 1'b1;
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    spur = 1'b0;
    checks++;
    if ({req_seen, if2id_valid} !== 2'b00) begin
      failures++; $display("FAIL boot_spurious: got req=%b valid=%b want 0 0", req_seen, if2id_valid);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({req_seen, addr_seen} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL reset_refetch: got %b %h want 1 0", req_seen, addr_seen);
    end
  endtask

  task automatic test_wrap();
    logic        prev_acc;
    logic [31:0] prev_addr, e;
    w_rst_b = 1'b0; w_stall = 1'b0; w_flush = 1'b0; w_tgt = 32'h0;
    w_ready = 1'b1; w_rvalid = 1'b0; w_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if ({w_req, w_addr, w_pc, w_instr} !== {1'b0, WRAP_RV, WRAP_RV, NOP}) begin
      failures++; $display("FAIL wrap_reset: got req=%b addr=%h pc=%h instr=%h", w_req, w_addr, w_pc, w_instr);
    end
    w_rst_b = 1'b1; prev_acc = 1'b0; prev_addr = 32'h0;
    for (int k = 1; k <= 7; k++) begin
      w_rvalid = prev_acc;
      w_rdata  = prev_addr;
      #1;
      e = WRAP_RV + 32'(4 * (k - 2));
      checks++;
      if (w_req !== (k >= 2) || (k >= 2 && w_addr !== e)) begin
        failures++; $display("FAIL wrap_req c%0d: got req=%b addr=%h want %h", k, w_req, w_addr, e);
      end
      prev_acc  = w_req && w_ready;
      prev_addr = w_addr;
      @(negedge clk);
      e = WRAP_RV + 32'(4 * (k - 3));
      if (k >= 3) begin
        checks++;
        if ({w_valid, w_pc, w_instr} !== {1'b1, e, e}) begin
          failures++; $display("FAIL wrap_ifid c%0d: got %b %h %h want pc %h", k, w_valid, w_pc, w_instr, e);
        end
      end
    end
  endtask

  // Abstract model: fetch addresses and delivered PCs are each a +4 sequence restarted by every flush.
  task automatic test_random();
    logic [31:0] exp_fetch, exp_pc, tgt;
    logic [64:0] prev_ifid;
    logic        st, fl, rd;
    int          delivered;
    do_reset(); rst_b = 1'b1;
    data_key  = $urandom;
    exp_fetch = 32'h0;
    exp_pc    = 32'h0;
    delivered = 0;
    for (int i = 0; i < 2000; i++) begin
      st  = ($urandom % 10) < 3;
      fl  = ($urandom % 20) == 0;
      rd  = ($urandom % 10) < 7;
      lat = int'($urandom % 3);
      tgt = $urandom;
      prev_ifid = {if2id_valid, if2id_pc, if2id_instr};
      tick(st, fl, tgt, rd);
      if (req_seen) begin
        checks++;
        if (addr_seen !== exp_fetch) begin
          failures++; $display("FAIL rnd_fetch_addr i%0d: got %h want %h", i, addr_seen, exp_fetch);
        end
      end
      if (acc_seen) exp_fetch = exp_fetch + 32'd4;
      if (fl) begin
        checks++;
        if ({req_seen, if2id_valid, if2id_instr} !== {1'b0, 1'b0, NOP}) begin
          failures++; $display("FAIL rnd_flush i%0d: got req=%b valid=%b instr=%h", i, req_seen, if2id_valid, if2id_instr);
        end
        exp_fetch = {tgt[31:2], 2'b00};
        exp_pc    = {tgt[31:2], 2'b00};
      end else if (st) begin
        checks++;
        if ({if2id_valid, if2id_pc, if2id_instr} !== prev_ifid) begin
          failures++; $display("FAIL rnd_stall_hold i%0d: got %b %h %h want %h", i, if2id_valid, if2id_pc, if2id_instr, prev_ifid);
        end
      end else if (if2id_valid) begin
        checks++;
        if ({if2id_pc, if2id_instr} !== {exp_pc, exp_pc ^ data_key}) begin
          failures++; $display("FAIL rnd_deliver i%0d: got pc=%h instr=%h want pc=%h instr=%h",
                               i, if2id_pc, if2id_instr, exp_pc, exp_pc ^ data_key);
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end
    checks++;
    if (delivered < 100) begin
      failures++; $display("FAIL rnd_progress: delivered %0d want at least 100", delivered);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_b = 1'b0; w_rst_b = 1'b0; spur = 1'b0; pend = 1'b0; lat = 0; data_key = 32'h0;
    pend_addr = 32'h0; pend_wait = 0;
    w_stall = 1'b0; w_flush = 1'b0; w_tgt = 32'h0; w_ready = 1'b1; w_rvalid = 1'b0; w_rdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_flush_outstanding();
    test_flush_stall();
    test_backpressure();
    test_async_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the veriRISCV five-stage pipeline. It owns the program counter and issues word fetches on the instruction bus. It registers fetched instructions into the IF/ID pipeline register. It obeys the hazard unit's `if_stall` and `if_flush` controls, redirecting to `branch_target` on a flush and discarding any fetch that was in flight when the flush occurred.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: address of the first fetch after reset; bits [1:0] must be 0.
- `NOP_INSTR`, default 32'h0000_0013: value `if2id_instr` takes on reset and on flush (`addi x0,x0,0`).

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge
- `rst_b`  in  1  reset; asynchronous, active-low
- `if_stall`  in  1  hold the IF/ID register and do not accept a new fetch result into it
- `if_flush`  in  1  redirect the PC to `branch_target`; kill IF/ID and any in-flight fetch
- `branch_target`  in  32  redirect address; bits [1:0] are ignored (treated as 0)
- `ibus_req`  out  1  fetch request valid
- `ibus_addr`  out  32  fetch word address; bits [1:0] are always 0
- `ibus_ready`  in  1  bus accepts the request this cycle (`req & ready` = accept)
- `ibus_rvalid`  in  1  read data valid; responses arrive in order, at least 1 cycle after accept
- `ibus_rdata`  in  32  fetched instruction
- `if2id_valid`  out  1  IF/ID holds a real instruction
- `if2id_pc`  out  32  PC of the instruction in IF/ID
- `if2id_instr`  out  32  instruction in IF/ID

## Operation
- Registers:
  - `pc`: next address to request.
  - `req_pc`: PC of the outstanding fetch.
  - `discard`: outstanding response must be dropped.
  - `hold_valid`, `hold_pc`, `hold_instr`: one-entry holding buffer.
  - `if2id_*`: the IF/ID outputs.
- At most one fetch is outstanding at any time.
- FSM states and transitions:
  - BOOT: entered on reset; no request. Moves to REQ on the next cycle.
  - REQ: drives `ibus_req`. On accept: `req_pc<=pc`, `pc<=pc+4` (wraps modulo 2^32), and the FSM moves to WAIT.
  - WAIT: waits for `ibus_rvalid`. On a response, the next request may be issued in the same cycle, which gives a throughput of 1 instruction/cycle with a 1-cycle-latency memory.
- `ibus_req` is asserted when both of the following hold:
  - The FSM is in REQ, or in WAIT with `ibus_rvalid`.
  - `!if_flush`, and `hold_valid` is 0 after this cycle's update (no request while the buffer would stay full).
- Response handling, evaluated in the cycle `ibus_rvalid` is high:
  - If `discard` is set, drop the data and clear `discard`.
  - Else, if `!if_stall`, load `{1,req_pc,rdata}` into IF/ID.
  - Else, if the stall is active, load it into the holding buffer.
- IF/ID update when `!if_stall` and `!if_flush`, in priority order:
  1. A valid holding buffer moves into IF/ID and the buffer clears.
  2. Otherwise a live response is loaded into IF/ID.
  3. Otherwise IF/ID takes a bubble (`if2id_valid<=0`, pc/instr unchanged).
- With `if_stall=1`, IF/ID holds its value.
- Flush (`if_flush=1`) dominates a simultaneous stall:
  - `pc<=branch_target&~3`.
  - `if2id_valid<=0`, `if2id_instr<=NOP_INSTR`.
  - `hold_valid<=0`.
  - If a fetch is outstanding and its response is not arriving this cycle, set `discard`. A response arriving in the flush cycle is dropped directly.
  - The FSM goes to REQ, or stays in WAIT if `discard` was set.
- While `discard` is set, WAIT returns to REQ on the dropped response, with no same-cycle reissue.
- Reset mid-operation: all state returns immediately to reset values. A response arriving after reset release while in BOOT is ignored.

## Timing
- Reset values:
  - `ibus_req=0`, `ibus_addr=RESET_VECTOR`.
  - `if2id_valid=0`, `if2id_pc=RESET_VECTOR`, `if2id_instr=NOP_INSTR`.
  - `pc=RESET_VECTOR`, `discard=0`, `hold_valid=0`, FSM=BOOT.
- First `ibus_req` is asserted in the 2nd rising-edge cycle after `rst_b` deasserts.
- Fetch latency with `ready=1` and 1-cycle rvalid:
  - Request in cycle N.
  - `rvalid` in cycle N+1.
  - `if2id_valid=1` from cycle N+2.
- Redirect: with `if_flush` in cycle N, the earliest request to the target is in cycle N+1 (no outstanding fetch) or in the cycle after the dropped response.
- `ibus_addr` is stable while `ibus_req=1 & ibus_ready=0`.
- Outputs are registered except `ibus_req`/`ibus_addr`, which may depend combinationally on `ibus_rvalid`, `if_flush` and `if_stall`.

## Test plan
- **Reset and streaming:** reset release, then `ready=1` with 1-cycle memory returning `rdata=addr`.
  - Requests go to 0x0, 0x4, 0x8 … on consecutive cycles.
  - `if2id_pc` steps 0x0, 0x4, … with `if2id_valid=1` from the 4th cycle.
- **Stall with holding buffer:** assert `if_stall` for 3 cycles mid-stream.
  - IF/ID holds PC 0x8.
  - Exactly one response (0xC) is buffered and no further request is issued.
  - After release, 0xC, then 0x10 appear with no gap or duplicate.
- **Flush with outstanding fetch:** `if_flush` with `branch_target=0x100` while fetch 0x20 is in WAIT and `rvalid` is delayed 3 cycles.
  - 0x20 data is dropped.
  - Next request is 0x100.
  - `if2id_valid=0` until 0x100 arrives.
- **Flush and stall together:** assert both with `branch_target=0x203`.
  - `if2id_valid=0`, `if2id_instr=NOP_INSTR`.
  - Next request address is 0x200.
- **Backpressure:** `ibus_ready=0` for 4 cycles.
  - `ibus_req` stays high with `ibus_addr` stable.
  - `if2id_valid` goes 0 (bubbles) until data returns.
- **Wrap and async reset:**
  - With `RESET_VECTOR=32'hFFFF_FFF8`, requests go to …FFF8, …FFFC, 0x0.
  - Asserting `rst_b` low mid-WAIT immediately restores all reset values.
